// File: rtl/dequant_qt_qscale_if.sv
`default_nettype none
// ============================================================================
// Module   : dequant_qt_qscale_if
// Purpose  : Block handshake bundle between the entropy decoder, the inverse
//            quantizer and the IDCT.
// Revision : 1.0
// ============================================================================
interface dequant_qt_qscale_if;
    logic               input_valid;
    logic               input_ready;
    logic signed [31:0] INPUT_DATA [0:7][0:7];
    logic signed [31:0] QSCALE;
    logic               is_y;
    logic signed [31:0] Y_QMAT     [0:7][0:7];
    logic signed [31:0] C_QMAT     [0:7][0:7];
    logic               output_valid;
    logic               output_ready;
    logic signed [31:0] OUTPUT_DATA [0:7][0:7];

    modport master (
        output input_valid, INPUT_DATA, QSCALE, is_y, Y_QMAT, C_QMAT, output_ready,
        input  input_ready, output_valid, OUTPUT_DATA
    );

    modport slave (
        input  input_valid, INPUT_DATA, QSCALE, is_y, Y_QMAT, C_QMAT, output_ready,
        output input_ready, output_valid, OUTPUT_DATA
    );
endinterface
`default_nettype wire

// File: rtl/dequant_qt_qscale.sv
`default_nettype none
// ============================================================================
// Module   : dequant_qt_qscale
// Purpose  : 8x8 inverse quantizer, coef * QSCALE * QMAT / 4 with saturation,
//            ROWS_PER_CYCLE rows per clock, whole block held under backpressure.
// Revision : 1.0
// ============================================================================
module dequant_qt_qscale #(
    parameter int ROWS_PER_CYCLE = 1
) (
    input  wire logic          CLOCK,
    input  wire logic          RESET,
    dequant_qt_qscale_if.slave bus
);
    localparam logic [2:0] c_LAST_GROUP = 3'(8 - ROWS_PER_CYCLE);
    localparam logic [2:0] c_ROW_STEP   = 3'(ROWS_PER_CYCLE);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_accept;
    logic               w_last_group;
    logic [2:0]         r_row;
    logic signed [31:0] r_qscale;
    logic signed [31:0] r_in_buf   [0:7][0:7];
    logic signed [31:0] r_qmat     [0:7][0:7];
    logic signed [31:0] r_res_buf  [0:7][0:7];
    logic signed [31:0] r_out_data [0:7][0:7];
    logic signed [31:0] w_row_val  [0:ROWS_PER_CYCLE-1][0:7];

    // Full 64-bit product, divide by 4 truncating toward zero, clamp to int32.
    function automatic logic signed [31:0] f_dequant(
        input logic signed [31:0] a,
        input logic signed [31:0] q,
        input logic signed [31:0] m
    );
        logic signed [63:0] w_p;
        logic signed [63:0] w_r;
        w_p = $signed({{32{a[31]}}, a}) * $signed({{32{q[31]}}, q})
            * $signed({{32{m[31]}}, m});
        w_r = (w_p + ((w_p < 0) ? 64'sd3 : 64'sd0)) >>> 2;
        if (w_r > 64'sh0000_0000_7FFF_FFFF)
            return 32'sh7FFF_FFFF;
        else if (w_r < 64'shFFFF_FFFF_8000_0000)
            return 32'sh8000_0000;
        else
            return $signed(w_r[31:0]);
    endfunction

    always_ff @(posedge CLOCK) begin
        if (!RESET)
            r_state <= ST_IDLE;
        else
            r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_last_group = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.input_valid && RESET) begin
                    w_accept     = 1'b1;
                    w_next_state = ST_CALC;
                end
            end
            ST_CALC: begin
                if (r_row == c_LAST_GROUP) begin
                    w_last_group = 1'b1;
                    w_next_state = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.output_ready)
                    w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
            for (int j = 0; j < 8; j++) begin
                w_row_val[k][j] = f_dequant(r_in_buf[r_row + 3'(k)][j], r_qscale,
                                            r_qmat[r_row + 3'(k)][j]);
            end
        end
    end

    always_ff @(posedge CLOCK) begin
        if (!RESET) begin
            r_row    <= '0;
            r_qscale <= '0;
            for (int i = 0; i < 8; i++) begin
                for (int j = 0; j < 8; j++) begin
                    r_in_buf[i][j]   <= '0;
                    r_qmat[i][j]     <= '0;
                    r_res_buf[i][j]  <= '0;
                    r_out_data[i][j] <= '0;
                end
            end
        end else begin
            if (w_accept) begin
                r_row    <= '0;
                r_qscale <= bus.QSCALE;
                for (int i = 0; i < 8; i++) begin
                    for (int j = 0; j < 8; j++) begin
                        r_in_buf[i][j] <= bus.INPUT_DATA[i][j];
                        r_qmat[i][j]   <= bus.is_y ? bus.Y_QMAT[i][j] : bus.C_QMAT[i][j];
                    end
                end
            end
            if (r_state == ST_CALC) begin
                r_row <= r_row + c_ROW_STEP;
                if (w_last_group) begin
                    for (int i = 0; i < 8; i++) begin
                        for (int j = 0; j < 8; j++) begin
                            r_out_data[i][j] <= r_res_buf[i][j];
                        end
                    end
                end
                // Later assignments override the bulk copy for the final row group.
                for (int k = 0; k < ROWS_PER_CYCLE; k++) begin
                    for (int j = 0; j < 8; j++) begin
                        r_res_buf[r_row + 3'(k)][j] <= w_row_val[k][j];
                        if (w_last_group)
                            r_out_data[r_row + 3'(k)][j] <= w_row_val[k][j];
                    end
                end
            end
        end
    end

    assign bus.input_ready  = (r_state == ST_IDLE) && RESET;
    assign bus.output_valid = (r_state == ST_DONE);
    assign bus.OUTPUT_DATA  = r_out_data;
endmodule
`default_nettype wire

// File: tb/tb_dequant_qt_qscale.sv
`default_nettype none
// ============================================================================
// Module   : tb_dequant_qt_qscale
// Purpose  : Self-checking bench for dequant_qt_qscale at 1, 2, 4, 8 rows/clock.
// Revision : 1.0
// ============================================================================
module tb_dequant_qt_qscale;
    typedef logic signed [31:0] blk_t [0:7][0:7];

    localparam longint c_MAX = 64'sd2147483647;
    localparam longint c_MIN = -64'sd2147483648;

    logic CLOCK = 1'b0;
    logic RESET = 1'b0;
    int   nchk  = 0;
    int   nfail = 0;

    blk_t               din, ymat, cmat, expd;
    logic signed [31:0] qs;
    logic               isy;

    always #5 CLOCK = ~CLOCK;

    dequant_qt_qscale_if bus ();
    dequant_qt_qscale_if b2 ();
    dequant_qt_qscale_if b4 ();
    dequant_qt_qscale_if b8 ();

    dequant_qt_qscale #(.ROWS_PER_CYCLE(1)) u_dut  (.CLOCK(CLOCK), .RESET(RESET), .bus(bus));
    dequant_qt_qscale #(.ROWS_PER_CYCLE(2)) u_rpc2 (.CLOCK(CLOCK), .RESET(RESET), .bus(b2));
    dequant_qt_qscale #(.ROWS_PER_CYCLE(4)) u_rpc4 (.CLOCK(CLOCK), .RESET(RESET), .bus(b4));
    dequant_qt_qscale #(.ROWS_PER_CYCLE(8)) u_rpc8 (.CLOCK(CLOCK), .RESET(RESET), .bus(b8));

    // The wider variants see exactly the same stimulus as the main instance.
    assign b2.input_valid = bus.input_valid;  assign b4.input_valid = bus.input_valid;  assign b8.input_valid = bus.input_valid;
    assign b2.INPUT_DATA  = bus.INPUT_DATA;   assign b4.INPUT_DATA  = bus.INPUT_DATA;   assign b8.INPUT_DATA  = bus.INPUT_DATA;
    assign b2.QSCALE      = bus.QSCALE;       assign b4.QSCALE      = bus.QSCALE;       assign b8.QSCALE      = bus.QSCALE;
    assign b2.is_y        = bus.is_y;         assign b4.is_y        = bus.is_y;         assign b8.is_y        = bus.is_y;
    assign b2.Y_QMAT      = bus.Y_QMAT;       assign b4.Y_QMAT      = bus.Y_QMAT;       assign b8.Y_QMAT      = bus.Y_QMAT;
    assign b2.C_QMAT      = bus.C_QMAT;       assign b4.C_QMAT      = bus.C_QMAT;       assign b8.C_QMAT      = bus.C_QMAT;
    assign b2.output_ready = bus.output_ready; assign b4.output_ready = bus.output_ready; assign b8.output_ready = bus.output_ready;

    // Reference: exact integer product, C-style division by 4, clamp to int32.
    function automatic blk_t model(input blk_t d, input logic signed [31:0] q, input blk_t m);
        blk_t   r;
        longint p, v;
        for (int i = 0; i < 8; i++) begin
            for (int j = 0; j < 8; j++) begin
                p = longint'(d[i][j]) * longint'(q) * longint'(m[i][j]);
                v = p / 4;
                if (v > c_MAX)      r[i][j] = 32'h7FFF_FFFF;
                else if (v < c_MIN) r[i][j] = 32'h8000_0000;
                else                r[i][j] = 32'(v);
            end
        end
        return r;
    endfunction

    function automatic int count_mis(input blk_t got, input blk_t ex);
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (got[i][j] !== ex[i][j]) n++;
        return n;
    endfunction

    function automatic int count_nonzero(input blk_t got);
        int n = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (got[i][j] !== 32'sd0) n++;
        return n;
    endfunction

    task automatic fill(output blk_t b, input logic signed [31:0] v);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                b[i][j] = v;
    endtask

    task automatic rand_block(output blk_t b, input bit full);
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                b[i][j] = full ? 32'($urandom) : 32'($urandom_range(65535)) - 32'd32768;
    endtask

    task automatic drive_inputs();
        bus.INPUT_DATA = din;
        bus.QSCALE     = qs;
        bus.is_y       = isy;
        bus.Y_QMAT     = ymat;
        bus.C_QMAT     = cmat;
    endtask

    task automatic accept_block();
        drive_inputs();
        bus.input_valid = 1'b1;
        @(negedge CLOCK);
        bus.input_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge CLOCK);
            if (bus.output_valid === 1'b1) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic drain();
        bus.output_ready = 1'b1;
        @(negedge CLOCK);
        bus.output_ready = 1'b0;
    endtask

    task automatic test_reset();
        rand_block(din, 1'b1); rand_block(ymat, 1'b0); rand_block(cmat, 1'b0);
        qs = 32'sd7; isy = 1'b1;
        drive_inputs();
        RESET = 1'b0; bus.input_valid = 1'b1; bus.output_ready = 1'b0;
        repeat (3) begin
            @(negedge CLOCK);
            nchk++; if (bus.input_ready !== 1'b0) begin nfail++; $display("FAIL reset_input_ready: got %b required 0", bus.input_ready); end
            nchk++; if (bus.output_valid !== 1'b0) begin nfail++; $display("FAIL reset_output_valid: got %b required 0", bus.output_valid); end
            nchk++; if (count_nonzero(bus.OUTPUT_DATA) != 0) begin nfail++; $display("FAIL reset_output_zero: %0d nonzero elements, required 0", count_nonzero(bus.OUTPUT_DATA)); end
        end
        bus.input_valid = 1'b0;
        RESET = 1'b1;
        @(negedge CLOCK);
        nchk++; if (bus.input_ready !== 1'b1) begin nfail++; $display("FAIL release_input_ready: got %b required 1", bus.input_ready); end
        nchk++; if (bus.output_valid !== 1'b0) begin nfail++; $display("FAIL release_no_accept: output_valid %b required 0", bus.output_valid); end
    endtask

    task automatic test_basic_luma();
        int lat, bad;
        fill(din, 32'sd3); fill(ymat, 32'sd4); rand_block(cmat, 1'b0);
        qs = 32'sd4; isy = 1'b1;
        accept_block();
        bus.QSCALE = 32'sd9; bus.is_y = 1'b0;
        wait_valid(lat);
        nchk++; if (lat != 8) begin nfail++; $display("FAIL basic_latency: got %0d required 8", lat); end
        bad = 0;
        for (int i = 0; i < 8; i++)
            for (int j = 0; j < 8; j++)
                if (bus.OUTPUT_DATA[i][j] !== 32'sd12) bad++;
        nchk++; if (bad != 0) begin nfail++; $display("FAIL basic_values: %0d elements differ from 12 (e.g. [0][0]=%0d)", bad, bus.OUTPUT_DATA[0][0]); end
        drain();
        nchk++; if (bus.output_valid !== 1'b0 || bus.input_ready !== 1'b1) begin nfail++; $display("FAIL basic_transfer: valid=%b ready=%b required 0/1", bus.output_valid, bus.input_ready); end
    endtask

    task automatic test_rounding_chroma();
        int lat;
        int rexp [8] = '{1, -1, 0, 0, 1, -1, 0, 1};
        int rin  [8] = '{5, -5, -1, 1, 7, -7, 0, 4};
        rand_block(din, 1'b0);
        for (int j = 0; j < 8; j++) din[0][j] = 32'(rin[j]);
        fill(cmat, 32'sd1); fill(ymat, 32'sd99);
        qs = 32'sd1; isy = 1'b0;
        expd = model(din, qs, cmat);
        accept_block();
        wait_valid(lat);
        nchk++; if (lat != 8) begin nfail++; $display("FAIL rounding_latency: got %0d required 8", lat); end
        for (int j = 0; j < 8; j++) begin
            nchk++; if (bus.OUTPUT_DATA[0][j] !== 32'(rexp[j])) begin nfail++; $display("FAIL rounding_row0[%0d]: got %0d required %0d", j, bus.OUTPUT_DATA[0][j], rexp[j]); end
        end
        nchk++; if (count_mis(bus.OUTPUT_DATA, expd) != 0) begin nfail++; $display("FAIL chroma_block: %0d elements wrong, required 0", count_mis(bus.OUTPUT_DATA, expd)); end
        drain();
    endtask

    task automatic test_saturation();
        int lat;
        rand_block(din, 1'b0);
        din[0][0] = 32'h7FFF_FFFF; din[0][1] = 32'h8000_0000;
        fill(ymat, 32'sd255); rand_block(cmat, 1'b0);
        qs = 32'sd255; isy = 1'b1;
        expd = model(din, qs, ymat);
        accept_block();
        wait_valid(lat);
        nchk++; if (bus.OUTPUT_DATA[0][0] !== 32'h7FFF_FFFF) begin nfail++; $display("FAIL sat_pos: got %h required 7fffffff", bus.OUTPUT_DATA[0][0]); end
        nchk++; if (bus.OUTPUT_DATA[0][1] !== 32'h8000_0000) begin nfail++; $display("FAIL sat_neg: got %h required 80000000", bus.OUTPUT_DATA[0][1]); end
        nchk++; if (count_mis(bus.OUTPUT_DATA, expd) != 0) begin nfail++; $display("FAIL sat_block: %0d elements wrong, required 0", count_mis(bus.OUTPUT_DATA, expd)); end
        drain();
    endtask

    task automatic test_random();
        int lat;
        for (int t = 0; t < 8; t++) begin
            rand_block(din, t[0]); rand_block(ymat, 1'b0); rand_block(cmat, 1'b0);
            qs  = 32'($urandom_range(65535)) - 32'd32768;
            isy = 1'($urandom);
            if (isy) expd = model(din, qs, ymat);
            else     expd = model(din, qs, cmat);
            accept_block();
            wait_valid(lat);
            nchk++; if (lat != 8) begin nfail++; $display("FAIL random_latency[%0d]: got %0d required 8", t, lat); end
            nchk++; if (count_mis(bus.OUTPUT_DATA, expd) != 0) begin nfail++; $display("FAIL random_block[%0d]: %0d elements wrong, [0][0]=%0d required %0d", t, count_mis(bus.OUTPUT_DATA, expd), bus.OUTPUT_DATA[0][0], expd[0][0]); end
            drain();
        end
    endtask

    task automatic test_back_to_back();
        blk_t expa, expb;
        int   lat, period;
        bit   seen_b;
        rand_block(din, 1'b1); rand_block(ymat, 1'b0); rand_block(cmat, 1'b0);
        qs = 32'sd1000; isy = 1'b1;
        expa = model(din, qs, ymat);
        accept_block();
        wait_valid(lat);
        // Second block offered while the first is stalled in DONE.
        rand_block(din, 1'b0); qs = 32'sd77; isy = 1'b0;
        expb = model(din, qs, cmat);
        drive_inputs();
        bus.input_valid = 1'b1;
        repeat (5) begin
            @(negedge CLOCK);
            nchk++; if (bus.output_valid !== 1'b1) begin nfail++; $display("FAIL bp_valid_hold: got %b required 1", bus.output_valid); end
            nchk++; if (bus.input_ready !== 1'b0) begin nfail++; $display("FAIL bp_busy_ready: got %b required 0", bus.input_ready); end
            nchk++; if (count_mis(bus.OUTPUT_DATA, expa) != 0) begin nfail++; $display("FAIL bp_data_hold: %0d elements changed, required 0", count_mis(bus.OUTPUT_DATA, expa)); end
        end
        bus.output_ready = 1'b1;
        @(negedge CLOCK);
        nchk++; if (bus.output_valid !== 1'b0 || bus.input_ready !== 1'b1) begin nfail++; $display("FAIL bp_transfer: valid=%b ready=%b required 0/1", bus.output_valid, bus.input_ready); end
        @(negedge CLOCK);
        rand_block(din, 1'b1); qs = 32'sd3; isy = 1'b1;
        expd = model(din, qs, ymat);
        drive_inputs();
        period = -1; seen_b = 1'b0;
        for (int n = 1; n <= 30; n++) begin
            @(negedge CLOCK);
            if (bus.output_valid === 1'b1 && !seen_b) begin
                seen_b = 1'b1;
                nchk++; if (count_mis(bus.OUTPUT_DATA, expb) != 0) begin nfail++; $display("FAIL b2b_second_block: %0d elements wrong, required 0", count_mis(bus.OUTPUT_DATA, expb)); end
            end
            if (bus.input_ready === 1'b1) begin
                period = n + 1;
                break;
            end
        end
        nchk++; if (period != 10) begin nfail++; $display("FAIL b2b_period: got %0d required 10", period); end
        @(negedge CLOCK);
        bus.input_valid = 1'b0; bus.output_ready = 1'b0;
        wait_valid(lat);
        nchk++; if (lat != 8 || count_mis(bus.OUTPUT_DATA, expd) != 0) begin nfail++; $display("FAIL b2b_third_block: latency %0d, %0d elements wrong, required 8 and 0", lat, count_mis(bus.OUTPUT_DATA, expd)); end
        drain();
    endtask

    task automatic test_reset_mid_calc();
        int lat [4];
        int mis [4];
        int pulses;
        RESET = 1'b0; bus.output_ready = 1'b0;
        @(negedge CLOCK);
        RESET = 1'b1;
        rand_block(din, 1'b1); rand_block(ymat, 1'b0); rand_block(cmat, 1'b0);
        qs = 32'sd5; isy = 1'b0;
        accept_block();
        repeat (4) @(negedge CLOCK);
        RESET = 1'b0;
        @(negedge CLOCK);
        nchk++; if ({bus.output_valid, b2.output_valid, b4.output_valid, b8.output_valid} !== 4'b0000) begin nfail++; $display("FAIL midcalc_valid: got %b%b%b%b required 0000", bus.output_valid, b2.output_valid, b4.output_valid, b8.output_valid); end
        nchk++; if (count_nonzero(bus.OUTPUT_DATA) + count_nonzero(b8.OUTPUT_DATA) != 0) begin nfail++; $display("FAIL midcalc_clear: %0d nonzero elements, required 0", count_nonzero(bus.OUTPUT_DATA) + count_nonzero(b8.OUTPUT_DATA)); end
        @(negedge CLOCK);
        RESET = 1'b1;
        pulses = 0;
        repeat (10) begin
            @(negedge CLOCK);
            if (bus.output_valid !== 1'b0) pulses++;
        end
        nchk++; if (pulses != 0) begin nfail++; $display("FAIL midcalc_no_pulse: %0d valid cycles, required 0", pulses); end
        rand_block(din, 1'b1); rand_block(ymat, 1'b0); rand_block(cmat, 1'b0);
        qs = 32'($urandom_range(4095)) - 32'd2048; isy = 1'b1;
        expd = model(din, qs, ymat);
        accept_block();
        lat = '{-1, -1, -1, -1};
        mis = '{-1, -1, -1, -1};
        for (int n = 1; n <= 20; n++) begin
            @(negedge CLOCK);
            if (lat[0] < 0 && bus.output_valid === 1'b1) begin lat[0] = n; mis[0] = count_mis(bus.OUTPUT_DATA, expd); end
            if (lat[1] < 0 && b2.output_valid === 1'b1)  begin lat[1] = n; mis[1] = count_mis(b2.OUTPUT_DATA, expd); end
            if (lat[2] < 0 && b4.output_valid === 1'b1)  begin lat[2] = n; mis[2] = count_mis(b4.OUTPUT_DATA, expd); end
            if (lat[3] < 0 && b8.output_valid === 1'b1)  begin lat[3] = n; mis[3] = count_mis(b8.OUTPUT_DATA, expd); end
        end
        for (int k = 0; k < 4; k++) begin
            nchk++; if (lat[k] != (8 >> k)) begin nfail++; $display("FAIL rpc%0d_latency: got %0d required %0d", 1 << k, lat[k], 8 >> k); end
            nchk++; if (mis[k] != 0) begin nfail++; $display("FAIL rpc%0d_data: %0d elements wrong, required 0", 1 << k, mis[k]); end
        end
        drain();
    endtask

    initial begin
        bus.input_valid  = 1'b0;
        bus.output_ready = 1'b0;
        fill(din, 32'sd0); fill(ymat, 32'sd0); fill(cmat, 32'sd0);
        qs = 32'sd0; isy = 1'b0;
        drive_inputs();
        test_reset();
        test_basic_luma();
        test_rounding_chroma();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_mid_calc();
        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/dequant_qt_qscale.md
# dequant_qt_qscale

Inverse quantizer for 8x8 coefficient blocks. It is the decode-side counterpart of the pre-quantization stage: it rebuilds each DCT coefficient as quantized value × QSCALE × QMAT / 4. It sits between the entropy decoder and the IDCT. A block is accepted with a valid/ready handshake and processed ROWS_PER_CYCLE rows per clock. The result is presented as a whole block held under output backpressure.

## Interface
- ROWS_PER_CYCLE, default 1: rows dequantized per clock. Legal values are 1, 2, 4, 8. NCYC = 8/ROWS_PER_CYCLE.
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  reset, synchronous, active-low.
- input_valid  in  1  INPUT_DATA, QSCALE, is_y and the matrices are valid.
- input_ready  out  1  block can be accepted. High only in IDLE with RESET high.
- INPUT_DATA  in  signed 32 ×[8][8]  quantized coefficients.
- QSCALE  in  signed 32  quantizer scale.
- is_y  in  1  1 selects Y_QMAT, 0 selects C_QMAT.
- Y_QMAT, C_QMAT  in  signed 32 ×[8][8]  luma and chroma weight matrices.
- output_valid  out  1  OUTPUT_DATA holds a complete block.
- output_ready  in  1  downstream accepts the block.
- OUTPUT_DATA  out  signed 32 ×[8][8]  dequantized coefficients.

## Operation
- **Accept.** A block is accepted on a rising edge where input_valid && input_ready. On that edge the block captures:
  - INPUT_DATA into an internal buffer;
  - QSCALE;
  - the selected matrix (Y_QMAT if is_y = 1, otherwise C_QMAT).
  Input changes after acceptance have no effect.
- **FSM states.**
  - IDLE → CALC on accept. Row counter is cleared to 0.
  - CALC: each clock processes rows row..row+ROWS_PER_CYCLE-1 into the result buffer, then row += ROWS_PER_CYCLE. After the last row group (row + ROWS_PER_CYCLE = 8), go to DONE. On that same edge the result buffer is copied to OUTPUT_DATA. The last row group's values are written directly into OUTPUT_DATA.
  - DONE: output_valid = 1. Transfer happens on an edge with output_ready = 1, then go to IDLE.
- **Arithmetic, per element.**
  - p = INPUT × QSCALE × QMAT, computed at signed 64-bit width. No intermediate truncation.
  - r = p / 4, truncated toward zero. Equivalent form: (p + (p<0 ? 3 : 0)) >>> 2.
  - r is saturated to signed 32-bit: greater than 2^31-1 → 32'h7FFFFFFF; less than -2^31 → 32'h80000000.
  - Zero or negative QSCALE/QMAT is handled by plain arithmetic. No special case.
- **OUTPUT_DATA stability.** OUTPUT_DATA changes only on entry to DONE and on reset. It stays stable in IDLE, CALC and DONE otherwise.
- **Input while busy.** input_valid while not in IDLE is ignored; nothing is queued.

## Timing
- **Reset values** (at any rising edge with RESET = 0):
  - state = IDLE, row = 0;
  - output_valid = 0;
  - OUTPUT_DATA all 0;
  - internal buffers 0;
  - input_ready = 0 while RESET = 0.
- **Reset mid-operation.** Reset in CALC or DONE aborts and discards the block. There is no partial output.
- **Latency.** Accept at edge E0 gives output_valid = 1 after edge E(NCYC), i.e. 8 clocks for ROWS_PER_CYCLE = 1 and 1 clock for ROWS_PER_CYCLE = 8.
- **Back-to-back throughput.** With output_ready held high:
  - output_valid drops after edge E(NCYC+1);
  - input_ready rises in the same cycle;
  - the earliest next accept is E(NCYC+2).
  Minimum period is NCYC+2 clocks per block.
- **Backpressure.** output_valid and OUTPUT_DATA hold indefinitely while output_ready = 0. output_ready while output_valid = 0 has no effect.
- **Output rules.** output_valid never deasserts without a transfer, except by reset. There is at most one block in flight.

## Test plan
- **Reset.** Hold RESET = 0 for 3 clocks with input_valid = 1.
  - During reset: input_ready = 0, output_valid = 0, OUTPUT_DATA all 0, nothing accepted.
  - First cycle after release: input_ready = 1.
- **Basic luma block.** is_y = 1, QSCALE = 4, Y_QMAT all 4, INPUT all 3, ROWS_PER_CYCLE = 1.
  - All outputs = 12.
  - output_valid rises exactly 8 clocks after accept.
  - Input changes after accept (QSCALE = 9, is_y = 0) do not alter the result.
- **Rounding and chroma select.** QSCALE = 1, C_QMAT all 1, is_y = 0, INPUT row 0 = {5, -5, -1, 1, 7, -7, 0, 4}.
  - Row 0 = {1, -1, 0, 0, 1, -1, 0, 1}.
  - Y_QMAT set to 99 must not affect the result.
- **Saturation.** INPUT[0][0] = 32'h7FFFFFFF and INPUT[0][1] = 32'h80000000, QSCALE = 255, QMAT = 255.
  - OUTPUT[0][0] = 32'h7FFFFFFF.
  - OUTPUT[0][1] = 32'h80000000.
- **Backpressure and busy.** Hold output_ready = 0 for 5 clocks in DONE while driving a second block.
  - OUTPUT_DATA and output_valid are held; input_ready = 0; the second block is not accepted.
  - Raise output_ready: transfer on the next edge, accept 1 clock later. Back-to-back period = 10 clocks.
- **Reset mid-CALC.** Assert RESET = 0 at row 4.
  - Outputs clear; no output_valid pulse.
  - The next block after release produces correct data. Repeat for ROWS_PER_CYCLE = 2, 4, 8: latency = 4, 2, 1.
